wishbone_bus_arbiter: RTL and testbench

N-to-1 Wishbone Classic arbiter that lets several bus masters (CPU, DMA, debug bridge) share one slave port, normally the master port of the peripheral bus splitter. Round-robin arbitration on CYC, grant locked for the owner's whole cycle, responses routed only to the owner. An optional watchdog terminates stalled accesses with ERR.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_rr_picker.sv | 41 ++++
 rtl/wishbone_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_wishbone_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared Wishbone definitions: arbiter state encoding and the
//            elaboration-time clog2 helper used by the Wishbone blocks.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  // Arbiter FSM encoding: the bus is either free or owned by one master.
  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  // Number of bits needed to encode 'value' distinct codes (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_picker
// Brief    : Combinational round-robin picker. Searches the request vector
//            starting one past last_owner, wrapping, and returns the first
//            active requester as a one-hot vector and as an index.
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_picker
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_WIDTH   = clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_WIDTH-1:0]   last_owner,
  output logic                   found,
  output logic [NUM_MASTERS-1:0] winner,
  output logic [IDX_WIDTH-1:0]   winner_idx
);

  logic [IDX_WIDTH-1:0] cand;

  // Walk the masters in rotating order; the previous owner is visited last.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    winner_idx = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_WIDTH'((int'(last_owner) + k) % NUM_MASTERS);
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wishbone_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_bus_arbiter
// Brief    : N-to-1 Wishbone Classic arbiter. Round-robin on CYC, grant held
//            for the owner's whole cycle, responses steered to the owner only,
//            optional watchdog that ends stalled strobes with ERR.
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_bus_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_ni,
  input  logic [NUM_MASTERS-1:0]            m_wb_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_wb_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_wb_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_wb_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wb_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_wb_sel_i,
  output logic [DATA_WIDTH-1:0]             m_wb_dat_o,
  output logic [NUM_MASTERS-1:0]            m_wb_ack_o,
  output logic [NUM_MASTERS-1:0]            m_wb_err_o,
  output logic                              s_wb_cyc_o,
  output logic                              s_wb_stb_o,
  output logic                              s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]             s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]             s_wb_dat_o,
  output logic [SEL_WIDTH-1:0]              s_wb_sel_o,
  input  logic [DATA_WIDTH-1:0]             s_wb_dat_i,
  input  logic                              s_wb_ack_i,
  input  logic                              s_wb_err_i,
  output logic [NUM_MASTERS-1:0]            arb_gnt_o
);

  localparam int IDX_WIDTH = clog2(NUM_MASTERS);
  localparam int CNT_BITS  = clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_WIDTH = (CNT_BITS < 1) ? 1 : CNT_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [IDX_WIDTH-1:0] LAST_RESET = IDX_WIDTH'(NUM_MASTERS - 1);
  localparam bit WATCHDOG_ON = (TIMEOUT_CYCLES != 0);

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] gnt;
  logic [IDX_WIDTH-1:0]   last_owner;
  logic [CNT_WIDTH-1:0]   wd_count;

  logic                   req_any;
  logic [NUM_MASTERS-1:0] winner;
  logic [IDX_WIDTH-1:0]   winner_idx;

  logic                   granted;
  logic                   owner_cyc;
  logic                   owner_stb;
  logic                   owner_we;
  logic [ADDR_WIDTH-1:0]  owner_adr;
  logic [DATA_WIDTH-1:0]  owner_dat;
  logic [SEL_WIDTH-1:0]   owner_sel;
  logic                   timeout_pulse;

  wb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_picker (
    .req        (m_wb_cyc_i),
    .last_owner (last_owner),
    .found      (req_any),
    .winner     (winner),
    .winner_idx (winner_idx)
  );

  // While granted last_owner is the current owner, so it doubles as the mux select.
  always_comb begin
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    owner_we  = 1'b0;
    owner_adr = '0;
    owner_dat = '0;
    owner_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (last_owner == IDX_WIDTH'(i)) begin
        owner_cyc = m_wb_cyc_i[i];
        owner_stb = m_wb_stb_i[i];
        owner_we  = m_wb_we_i[i];
        owner_adr = m_wb_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        owner_dat = m_wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        owner_sel = m_wb_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  // Bus routing: slave sees the owner only while granted; responses go to the owner only.
  // The watchdog yields to a real slave response in the same cycle so ACK and ERR never coexist.
  always_comb begin
    granted       = (state == ARB_GRANTED);
    timeout_pulse = WATCHDOG_ON && granted && owner_stb && !s_wb_ack_i && !s_wb_err_i
                    && (wd_count == CNT_LIMIT);
    s_wb_cyc_o    = granted & owner_cyc;
    s_wb_stb_o    = granted & owner_stb & ~timeout_pulse;
    s_wb_we_o     = granted & owner_we;
    s_wb_adr_o    = granted ? owner_adr : '0;
    s_wb_dat_o    = granted ? owner_dat : '0;
    s_wb_sel_o    = granted ? owner_sel : '0;
    m_wb_dat_o    = s_wb_dat_i;
    m_wb_ack_o    = gnt & {NUM_MASTERS{owner_stb & s_wb_ack_i}};
    m_wb_err_o    = gnt & {NUM_MASTERS{owner_stb & (s_wb_err_i | timeout_pulse)}};
    arb_gnt_o     = gnt;
  end

  // Arbitration FSM: grant on any request, hold until the owner drops CYC.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state      <= ARB_IDLE;
      gnt        <= '0;
      last_owner <= LAST_RESET;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (req_any) begin
            state      <= ARB_GRANTED;
            gnt        <= winner;
            last_owner <= winner_idx;
          end
        end
        ARB_GRANTED: begin
          if (!owner_cyc) begin
            state <= ARB_IDLE;
            gnt   <= '0;
          end
        end
      endcase
    end
  end

  // Stall watchdog: counts unanswered strobe cycles, saturates at the limit, clears after firing.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wd_count <= '0;
    end else if (!WATCHDOG_ON || !granted || !owner_stb || s_wb_ack_i || s_wb_err_i
                 || timeout_pulse) begin
      wd_count <= '0;
    end else if (wd_count != CNT_LIMIT) begin
      wd_count <= wd_count + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wishbone_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wishbone_bus_arbiter
// Brief    : Directed self-checking bench for wishbone_bus_arbiter with three
//            masters and a four-cycle watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wishbone_bus_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM*SW-1:0] m_sel;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack, m_err;
  logic             s_cyc, s_stb, s_we;
  logic [AW-1:0]    s_adr;
  logic [DW-1:0]    s_dat_o;
  logic [SW-1:0]    s_sel;
  logic [DW-1:0]    s_dat_i;
  logic             s_ack, s_err;
  logic [NM-1:0]    gnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wishbone_bus_arbiter #(
    .NUM_MASTERS    (NM),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .SEL_WIDTH      (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .m_wb_cyc_i (m_cyc),
    .m_wb_stb_i (m_stb),
    .m_wb_we_i  (m_we),
    .m_wb_adr_i (m_adr),
    .m_wb_dat_i (m_dat),
    .m_wb_sel_i (m_sel),
    .m_wb_dat_o (m_dat_o),
    .m_wb_ack_o (m_ack),
    .m_wb_err_o (m_err),
    .s_wb_cyc_o (s_cyc),
    .s_wb_stb_o (s_stb),
    .s_wb_we_o  (s_we),
    .s_wb_adr_o (s_adr),
    .s_wb_dat_o (s_dat_o),
    .s_wb_sel_o (s_sel),
    .s_wb_dat_i (s_dat_i),
    .s_wb_ack_i (s_ack),
    .s_wb_err_i (s_err),
    .arb_gnt_o  (gnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow a further settle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic set_master(input int i, input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input logic [SW-1:0] sel);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
    m_we[i]  = we;
    m_adr[i*AW +: AW] = adr;
    m_dat[i*DW +: DW] = dat;
    m_sel[i*SW +: SW] = sel;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    logic [NM-1:0] exp_gnt;
    int            owner;
    int            w;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    settle();
    check("rst_gnt",   gnt,   0);
    check("rst_s_cyc", s_cyc, 0);
    check("rst_s_stb", s_stb, 0);
    check("rst_s_adr", s_adr, 0);
    check("rst_ack",   m_ack, 0);
    check("rst_err",   m_err, 0);
    rst_n = 1'b1;

    // ---------------- single master write ----------------
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 4'hF);
    settle();
    check("s1_gnt_before", gnt,   0);
    check("s1_cyc_before", s_cyc, 0);
    tick(); settle();
    check("s1_gnt",   gnt,     3'b001);
    check("s1_s_cyc", s_cyc,   1);
    check("s1_s_adr", s_adr,   32'h0001_0004);
    check("s1_s_dat", s_dat_o, 32'hDEAD_BEEF);
    check("s1_s_we",  s_we,    1);
    check("s1_s_sel", s_sel,   4'hF);
    check("s1_ack0",  m_ack,   0);
    tick(); settle();
    check("s1_ack_early", m_ack, 0);
    tick();
    s_ack = 1'b1;
    settle();
    check("s1_ack",   m_ack, 3'b001);
    check("s1_s_stb", s_stb, 1);
    check("s1_err",   m_err, 0);
    tick();
    s_ack = 1'b0;
    set_master(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    check("s1_cyc_drop", s_cyc, 0);
    check("s1_gnt_hold", gnt,   3'b001);
    tick(); settle();
    check("s1_idle", gnt, 0);

    // ---------------- contention m0 vs m1 ----------------
    apply_reset();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, '0, 4'hF);
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, '0, 4'hF);
    tick(); settle();
    check("s2_gnt_m0", gnt,   3'b001);
    check("s2_adr_m0", s_adr, 32'h0000_1000);
    s_ack = 1'b1;
    s_dat_i = 32'h1234_5678;
    settle();
    check("s2_ack_m0", m_ack,   3'b001);
    check("s2_rdata",  m_dat_o, 32'h1234_5678);
    tick();
    s_ack = 1'b0;
    set_master(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick(); settle();
    check("s2_bubble",     gnt,   0);
    check("s2_bubble_cyc", s_cyc, 0);
    tick(); settle();
    check("s2_gnt_m1", gnt,   3'b010);
    check("s2_adr_m1", s_adr, 32'h0000_2000);
    s_ack = 1'b1;
    settle();
    check("s2_ack_m1", m_ack, 3'b010);
    tick();
    s_ack = 1'b0;
    set_master(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // ---------------- fairness, three continuous requesters ----------------
    apply_reset();
    m_cyc = 3'b111;
    for (int k = 0; k < 6; k++) begin
      owner   = k % 3;
      exp_gnt = 3'b001 << owner;
      settle();
      w = 0;
      while (gnt == 0 && w < 6) begin
        tick(); settle();
        w++;
      end
      check("fair_gnt", gnt, exp_gnt);
      for (int h = 0; h < 5; h++) tick();
      settle();
      check("fair_hold", gnt, exp_gnt);
      tick();
      m_cyc[owner] = 1'b0;
      tick();
      m_cyc[owner] = 1'b1;
    end
    clear_inputs();

    // ---------------- lock: m1 holds CYC over three accesses ----------------
    apply_reset();
    set_master(1, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_0055, 4'hF);
    tick(); settle();
    check("lock_gnt_m1", gnt, 3'b010);
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_4000, '0, 4'hF);
    for (int a = 0; a < 3; a++) begin
      s_ack = 1'b1;
      settle();
      check("lock_ack", m_ack, 3'b010);
      check("lock_gnt", gnt,   3'b010);
      tick();
      m_stb[1] = 1'b0;
      settle();
      check("lock_stb_low_drop", m_ack, 0);
      check("lock_gnt_gap",      gnt,   3'b010);
      tick();
      s_ack = 1'b0;
      m_stb[1] = 1'b1;
    end
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    settle();
    check("lock_gnt_last", gnt, 3'b010);
    tick(); settle();
    check("lock_bubble", gnt, 0);
    tick(); settle();
    check("lock_gnt_m0", gnt, 3'b001);
    clear_inputs();

    // ---------------- watchdog: slave never answers ----------------
    apply_reset();
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_5000, '0, 4'hF);
    set_master(2, 1'b1, 1'b1, 1'b0, 32'h0000_6000, '0, 4'hF);
    for (int c = 1; c <= 6; c++) begin
      tick(); settle();
      check("wd_gnt",   gnt,   3'b010);
      check("wd_err",   m_err, (c == 5) ? 3'b010 : 3'b000);
      check("wd_s_stb", s_stb, (c == 5) ? 1'b0 : 1'b1);
      check("wd_ack",   m_ack, 0);
    end
    clear_inputs();
    tick();
    tick();

    // ---------------- reset in the middle of an access ----------------
    apply_reset();
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h0000_7000, 32'h0000_A5A5, 4'hF);
    tick(); settle();
    check("rm_gnt_m0", gnt, 3'b001);
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_8000, '0, 4'hF);
    rst_n = 1'b0;
    settle();
    check("rm_sync", gnt, 3'b001);
    tick(); settle();
    check("rm_gnt",   gnt,     0);
    check("rm_s_cyc", s_cyc,   0);
    check("rm_s_stb", s_stb,   0);
    check("rm_s_we",  s_we,    0);
    check("rm_s_adr", s_adr,   0);
    check("rm_s_dat", s_dat_o, 0);
    check("rm_s_sel", s_sel,   0);
    rst_n = 1'b1;
    tick(); settle();
    check("rm_prio_m0", gnt, 3'b001);
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
